// File: rtl/clock_divider_mc.sv
// clock_divider_mc: divides one input clock into CHANNELS independent clocks.
// Each channel has its own divide ratio, high time and run enable, and emits a
// one-cycle tick on the first cycle of every output period. New ratios are
// queued per channel and switch in only at a period boundary, so a running
// output never loses or shortens a period.
module clock_divider_mc #(
  parameter int CHANNELS = 4,
  parameter int DIV_W    = 16,
  parameter int CH_W     = 2
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic [DIV_W-1:0]    cfg_high,
  input  logic [CHANNELS-1:0] en,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick
);

  localparam int NSEL = 1 << CH_W;

  logic [DIV_W-1:0]    r_div_a  [CHANNELS];
  logic [DIV_W-1:0]    r_high_a [CHANNELS];
  logic [DIV_W-1:0]    r_div_p  [CHANNELS];
  logic [DIV_W-1:0]    r_high_p [CHANNELS];
  logic [DIV_W-1:0]    r_cnt    [CHANNELS];
  logic [CHANNELS-1:0] r_pend;
  logic [CHANNELS-1:0] r_out;
  logic [CHANNELS-1:0] r_tick;
  logic [CHANNELS-1:0] r_byp;

  logic [NSEL-1:0]     w_pend_sel;
  logic [DIV_W-1:0]    w_high_clamp;
  logic [CHANNELS-1:0] w_acc;
  logic [CHANNELS-1:0] w_run;
  logic [CHANNELS-1:0] w_byp;
  logic [CHANNELS-1:0] w_wrap;

  // Pend flags widened to the full select range; codes with no channel behind
  // them read as "not pending", so such writes are accepted and dropped.
  always_comb begin
    w_pend_sel = '0;
    w_pend_sel[CHANNELS-1:0] = r_pend;
  end

  assign cfg_ready = !rst && !w_pend_sel[cfg_ch];

  // High time outside 1..D-1 falls back to floor(D/2); odd D leaves low one longer.
  always_comb begin
    w_high_clamp = cfg_div >> 1;
    if ((cfg_high != '0) && (cfg_high < cfg_div)) begin
      w_high_clamp = cfg_high;
    end
  end

  // Per-channel decode: write strobe, run/bypass mode and period wrap.
  always_comb begin
    w_acc  = '0;
    w_run  = '0;
    w_byp  = '0;
    w_wrap = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_acc[i]  = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
      w_run[i]  = en[i] && (r_div_a[i] >= DIV_W'(2));
      w_byp[i]  = en[i] && (r_div_a[i] == DIV_W'(1));
      w_wrap[i] = (r_cnt[i] == (r_div_a[i] - DIV_W'(1)));
    end
  end

  // Counters, registered outputs, and the pending -> active ratio handover.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_div_a[i]  <= '0;
        r_high_a[i] <= '0;
        r_div_p[i]  <= '0;
        r_high_p[i] <= '0;
        r_cnt[i]    <= '0;
      end
      r_pend <= '0;
      r_out  <= '0;
      r_tick <= '0;
      r_byp  <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_run[i]) begin
          r_out[i]  <= (r_cnt[i] < r_high_a[i]);
          r_tick[i] <= (r_cnt[i] == '0);
          r_cnt[i]  <= w_wrap[i] ? '0 : r_cnt[i] + DIV_W'(1);
        end else begin
          // Idle restarts from count 0 so re-enable is phase-aligned to en.
          r_out[i]  <= 1'b0;
          r_tick[i] <= w_byp[i];
          r_cnt[i]  <= '0;
        end
        r_byp[i] <= w_byp[i];

        // A running channel finishes its current period before switching.
        if (r_pend[i] && (!w_run[i] || w_wrap[i])) begin
          r_div_a[i]  <= r_div_p[i];
          r_high_a[i] <= r_high_p[i];
          r_pend[i]   <= 1'b0;
        end

        // Accept needs pend clear, so it never collides with the handover above.
        if (w_acc[i]) begin
          r_div_p[i]  <= cfg_div;
          r_high_p[i] <= w_high_clamp;
          r_pend[i]   <= 1'b1;
        end
      end
    end
  end

  // Bypass (D=1) passes clk_in through, gated by the registered enable.
  assign clk_out = r_out | (r_byp & {CHANNELS{clk_in}});
  assign tick    = r_tick;

endmodule

// File: tb/tb_clock_divider_mc.sv
// Bench for clock_divider_mc: a period-start/phase model checked every cycle,
// plus directed scenarios with hand-computed output patterns.
module tb_clock_divider_mc;
  localparam int CHANNELS = 4;
  localparam int DIV_W    = 16;
  localparam int CH_W     = 2;

  logic                clk_in;
  logic                rst;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [CH_W-1:0]     cfg_ch;
  logic [DIV_W-1:0]    cfg_div;
  logic [DIV_W-1:0]    cfg_high;
  logic [CHANNELS-1:0] en;
  logic [CHANNELS-1:0] clk_out;
  logic [CHANNELS-1:0] tick;

  int checks  = 0;
  int errors  = 0;
  int cyc_cnt = 0;
  int n_edge  = 0;

  // Model: active/pending ratio per channel and the edge at which the current
  // output period started.
  int m_div   [CHANNELS];
  int m_high  [CHANNELS];
  int m_pdiv  [CHANNELS];
  int m_phigh [CHANNELS];
  int m_t0    [CHANNELS];
  bit m_pend  [CHANNELS];
  bit m_act   [CHANNELS];
  logic [CHANNELS-1:0] e_out, e_tick, e_byp;

  logic [15:0] pat_o [CHANNELS];
  logic [15:0] pat_t [CHANNELS];

  clock_divider_mc #(.CHANNELS(CHANNELS), .DIV_W(DIV_W), .CH_W(CH_W)) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_high (cfg_high),
    .en       (en),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp_h(input int d, input int h);
    return (h > 0 && h < d) ? h : d / 2;
  endfunction

  task automatic model_apply(input int i);
    m_div[i]  = m_pdiv[i];
    m_high[i] = m_phigh[i];
    m_pend[i] = 1'b0;
  endtask

  // Advance the model by one clk_in edge using the inputs sampled at it.
  task automatic model_step();
    int p;
    bit acc;
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        m_div[i] = 0; m_high[i] = 0; m_pend[i] = 0; m_act[i] = 0; m_t0[i] = 0;
      end
      e_out = '0; e_tick = '0; e_byp = '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc = cfg_valid && (int'(cfg_ch) == i) && !m_pend[i];
        if (en[i] && m_div[i] >= 2) begin
          if (!m_act[i]) begin
            m_act[i] = 1'b1;
            m_t0[i]  = n_edge;
          end
          p = n_edge - m_t0[i];
          e_out[i]  = (p < m_high[i]);
          e_tick[i] = (p == 0);
          e_byp[i]  = 1'b0;
          if (p == m_div[i] - 1) begin
            m_t0[i] = n_edge + 1;
            if (m_pend[i]) model_apply(i);
          end
        end else begin
          m_act[i]  = 1'b0;
          e_out[i]  = 1'b0;
          e_byp[i]  = en[i] && (m_div[i] == 1);
          e_tick[i] = e_byp[i];
          if (m_pend[i]) model_apply(i);
        end
        if (acc) begin
          m_pend[i]  = 1'b1;
          m_pdiv[i]  = int'(cfg_div);
          m_phigh[i] = clamp_h(int'(cfg_div), int'(cfg_high));
        end
      end
    end
  endtask

  // Compare process: outputs checked against the model on both clock phases.
  initial begin
    forever begin
      @(posedge clk_in); #1;
      n_edge++;
      model_step();
      chk("clk_out_hi", 32'(clk_out), 32'(e_out | e_byp));
      chk("tick", 32'(tick), 32'(e_tick));
      chk("cfg_ready", 32'(cfg_ready), 32'(!rst && !m_pend[cfg_ch]));
      @(negedge clk_in); #1;
      chk("clk_out_lo", 32'(clk_out), 32'(e_out));
    end
  end

  task automatic nclk();
    @(negedge clk_in); #1;
  endtask

  task automatic cfg_write(input int ch, input int d, input int h);
    int k;
    nclk();
    cfg_valid = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_div   = DIV_W'(d);
    cfg_high  = DIV_W'(h);
    #1;
    k = 0;
    while (!cfg_ready && k < 50) begin
      nclk();
      k++;
    end
    chk("cfg_accept_bound", 32'(k < 50), 32'd1);
    nclk();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_applied(input int ch);
    int k;
    cfg_ch = CH_W'(ch);
    #1;
    k = 0;
    while (!cfg_ready && k < 50) begin
      nclk();
      k++;
    end
    chk("apply_bound", 32'(k < 50), 32'd1);
  endtask

  task automatic wait_tick(input int ch, output int t);
    int k;
    k = 0;
    do begin
      nclk();
      k++;
    end while (!tick[ch] && k < 50);
    chk("tick_bound", 32'(k < 50), 32'd1);
    t = cyc_cnt;
  endtask

  task automatic collect(input int n);
    for (int c = 0; c < CHANNELS; c++) begin
      pat_o[c] = '0;
      pat_t[c] = '0;
    end
    for (int k = 0; k < n; k++) begin
      nclk();
      for (int c = 0; c < CHANNELS; c++) begin
        pat_o[c] = {pat_o[c][14:0], clk_out[c]};
        pat_t[c] = {pat_t[c][14:0], tick[c]};
      end
    end
  endtask

  initial begin
    int t, t0, t1, t2, t3;
    rst = 1'b1; en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_high = '0;
    repeat (3) nclk();
    chk("rst_clk_out", 32'(clk_out), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd0);

    // ch0 D=4, H=0 -> clamped to 2
    rst = 1'b0;
    en  = 4'b0001;
    cfg_write(0, 4, 0);
    chk("s1_ready_pend", 32'(cfg_ready), 32'd0);
    nclk();
    chk("s1_ready_again", 32'(cfg_ready), 32'd1);
    chk("s1_out_before", 32'(clk_out[0]), 32'd0);
    collect(8);
    chk("s1_out_pat", 32'(pat_o[0][7:0]), 32'hCC);
    chk("s1_tick_pat", 32'(pat_t[0][7:0]), 32'h88);

    // ch1: D=5 H=2, then D=5 H=7 (clamped), then D=2
    en = 4'b0011;
    cfg_write(1, 5, 2);
    wait_applied(1);
    collect(10);
    chk("s2_d5h2_out", 32'(pat_o[1][9:0]), 32'b1100011000);
    chk("s2_d5h2_tick", 32'(pat_t[1][9:0]), 32'b1000010000);
    cfg_write(1, 5, 7);
    wait_applied(1);
    wait_tick(1, t);
    collect(4);
    chk("s2_d5h7_out", 32'(pat_o[1][3:0]), 32'b1000);
    chk("s2_d5h7_tick", 32'(pat_t[1][3:0]), 32'b0000);
    cfg_write(1, 2, 0);
    wait_applied(1);
    wait_tick(1, t);
    collect(5);
    chk("s2_d2_out", 32'(pat_o[1][4:0]), 32'b01010);
    chk("s2_d2_tick", 32'(pat_t[1][4:0]), 32'b01010);

    // ch0 D=6 running, D=3 written mid-period, second write must stall
    cfg_write(0, 6, 3);
    wait_applied(0);
    wait_tick(0, t0);
    cfg_write(0, 3, 0);
    cfg_valid = 1'b1;
    cfg_ch    = 2'd0;
    cfg_div   = 16'd8;
    cfg_high  = 16'd0;
    #1;
    chk("s3_stall_ready", 32'(cfg_ready), 32'd0);
    nclk();
    cfg_valid = 1'b0;
    wait_tick(0, t1);
    wait_tick(0, t2);
    wait_tick(0, t3);
    chk("s3_gap_old", 32'(t1 - t0), 32'd6);
    chk("s3_gap_new1", 32'(t2 - t1), 32'd3);
    chk("s3_gap_new2", 32'(t3 - t2), 32'd3);

    // All channels D=2,3,4,7 enabled together
    en = '0;
    nclk();
    cfg_write(0, 2, 0);
    cfg_write(1, 3, 0);
    cfg_write(2, 4, 0);
    cfg_write(3, 7, 0);
    wait_applied(3);
    en = 4'b1111;
    collect(8);
    chk("s4_ch0_out", 32'(pat_o[0][7:0]), 32'hAA);
    chk("s4_ch0_tick", 32'(pat_t[0][7:0]), 32'hAA);
    chk("s4_ch1_out", 32'(pat_o[1][7:0]), 32'h92);
    chk("s4_ch1_tick", 32'(pat_t[1][7:0]), 32'h92);
    chk("s4_ch2_out", 32'(pat_o[2][7:0]), 32'hCC);
    chk("s4_ch2_tick", 32'(pat_t[2][7:0]), 32'h88);
    chk("s4_ch3_out", 32'(pat_o[3][7:0]), 32'hE1);
    chk("s4_ch3_tick", 32'(pat_t[3][7:0]), 32'h81);
    en = 4'b1011;
    nclk();
    chk("s4_en2_off_out", 32'(clk_out[2]), 32'd0);
    chk("s4_en2_off_tick", 32'(tick[2]), 32'd0);
    nclk();
    en = 4'b1111;
    nclk();
    chk("s4_en2_on_out", 32'(clk_out[2]), 32'd1);
    chk("s4_en2_on_tick", 32'(tick[2]), 32'd1);
    repeat (10) nclk();

    // ch3 bypass (D=1), then disabled (D=0)
    cfg_write(3, 1, 0);
    wait_applied(3);
    nclk();
    chk("s5_byp_tick", 32'(tick[3]), 32'd1);
    chk("s5_byp_low", 32'(clk_out[3]), 32'd0);
    @(posedge clk_in); #1;
    chk("s5_byp_high", 32'(clk_out[3]), 32'd1);
    nclk();
    chk("s5_byp_tick2", 32'(tick[3]), 32'd1);
    cfg_write(3, 0, 0);
    wait_applied(3);
    nclk();
    chk("s5_d0_tick", 32'(tick[3]), 32'd0);
    chk("s5_d0_low", 32'(clk_out[3]), 32'd0);
    @(posedge clk_in); #1;
    chk("s5_d0_high", 32'(clk_out[3]), 32'd0);

    // Reset while running with a write pending on ch2
    wait_tick(2, t);
    cfg_write(2, 5, 0);
    chk("s6_pend_before", 32'(cfg_ready), 32'd0);
    rst = 1'b1;
    nclk();
    chk("s6_rst_out", 32'(clk_out), 32'd0);
    chk("s6_rst_tick", 32'(tick), 32'd0);
    chk("s6_rst_ready", 32'(cfg_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("s6_pend_cleared", 32'(cfg_ready), 32'd1);
    repeat (4) nclk();
    chk("s6_idle_out", 32'(clk_out), 32'd0);
    chk("s6_idle_tick", 32'(tick), 32'd0);
    repeat (2) nclk();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clock_divider_mc.md
# clock_divider_mc

Multi-channel programmable clock divider generating CHANNELS independent divided clocks and period-start ticks from one input clock. Each channel has its own divide ratio, programmable high time (duty cycle) and enable. Ratios are loaded at runtime through a valid/ready port and take effect only at a period boundary, so the output never glitches or truncates a period. It sits in the clock/timing subsystem and replaces single-channel dividers where several derived rates are needed.

## Interface
- CHANNELS, 4, number of independent divider channels (1..16)
- DIV_W, 16, width of divide ratio and high-time fields
- CH_W, 2, channel-select width; max(1, clog2(CHANNELS))
- clk_in  in  1  system clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config accepted on the edge where cfg_valid && cfg_ready
- cfg_ch  in  CH_W  target channel
- cfg_div  in  DIV_W  divide ratio D, output period = D clk_in cycles
- cfg_high  in  DIV_W  high-time H in clk_in cycles
- en  in  CHANNELS  per-channel run enable
- clk_out  out  CHANNELS  divided clocks
- tick  out  CHANNELS  one-cycle pulse marking first cycle of each output period

## Operation
- Per channel: active regs div_a/high_a, pending regs div_p/high_p, pend flag, counter cnt (DIV_W bits), registered out_r and tick_r.
- Reset: div_a=0, high_a=0, pend=0, cnt=0, out_r=0, tick_r=0; clk_out=0, tick=0, cfg_ready=0 while rst high.
- cfg_ready = !rst && !pend[cfg_ch] (combinational on cfg_ch). cfg_ch >= CHANNELS: cfg_ready=1, write dropped.
- Accept: div_p<=cfg_div, high_p<=H', pend<=1. H' = cfg_high if 0 < cfg_high < cfg_div, else floor(cfg_div/2) (clamp to ~50%; odd D gives low longer by one).
- Channel running: en=1 and div_a>=2. Otherwise idle.
- Running, each edge: out_r<=(cnt<high_a); tick_r<=(cnt==0); cnt<=(cnt==div_a-1)?0:cnt+1.
- Idle: cnt<=0, out_r<=0, tick_r<=0.
- Apply pending (div_a<=div_p, high_a<=high_p, pend<=0, cnt<=0): at the wrap edge (cnt==div_a-1) when running; on the next edge after acceptance when idle. Old ratio completes its full period.
- Accept and wrap on same edge with pend previously 0: no apply that edge; new values apply at following wrap.
- D=0: channel disabled (idle, outputs 0). D=1: bypass, clk_out[i]=clk_in gated by registered en, tick[i]=1 every cycle while en; switching into/out of bypass may produce a runt pulse (documented, not prevented).
- Channels fully independent; en toggling on one has no effect on others.

## Timing
- Enable latency: en rises at edge k (sampled) -> clk_out and tick high from edge k+1; tick high exactly one cycle per period.
- Output period D cycles, high for H cycles, low D-H cycles, starting at tick.
- Disable: en low sampled at edge k -> clk_out=0, tick=0 from edge k+1, cnt reset (restart is phase-aligned to en).
- Config to effect: idle channel, accept at edge k, apply at k+1, first tick at k+2 if en. Running channel: first new-ratio tick one cycle after the wrap edge.
- At most one pending write per channel; second write to same channel stalls (cfg_ready=0) until apply.
- rst mid-operation: all channels stop at next edge, pending writes discarded.

## Test plan
- Reset then write ch0 D=4 H=0, en[0]=1 -> clk_out[0] pattern 1,1,0,0 repeating, tick every 4 cycles, cfg_ready high again 1 cycle after accept.
- ch1 D=5 H=2 and D=5 H=7 -> high 2/low 3, then clamped high 2/low 3; D=2 -> alternating 1,0.
- ch0 running D=6, write D=3 mid-period -> current 6-cycle period completes, next tick 6 cycles after previous, then 3-cycle periods; second write during pend sees cfg_ready=0.
- All 4 channels D=2,3,4,7 simultaneously enabled -> each period correct, toggling en[2] changes only ch2; en[2] re-rise restarts with clk_out high 1 cycle later.
- D=1 on ch3 -> clk_out[3] follows clk_in, tick[3] constant 1; D=0 -> outputs 0.
- Assert rst for 1 cycle while running with pending write -> all outputs 0 next cycle, pend cleared, channels idle until reprogrammed.
